vending_customer: RTL and testbench

Transaction initiator for the vending machine; it drives the machine's coin-in/item-request side and collects its change/item side. It takes one purchase request at a time from an upstream valid/ready port and presents it to the machine for exactly one sampled cycle. It waits for the machine's OFF (delivery) cycle, captures the returned item and coins, and checks the change arithmetic. It then reports one response upstream. It serves as a system-level stimulus agent and as an on-chip self-checker.

---
 rtl/vending_pkg.sv | 44 ++++
 rtl/vending_coin_value.sv | 17 +
 rtl/vending_customer.sv | 191 +++++++++++++++++++
 tb/tb_vending_customer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine customer side: service, coin and item
// codes, coin values, item prices and the customer FSM state encoding.
package vending_pkg;

  localparam logic [1:0] SVC_OFF  = 2'b00;
  localparam logic [1:0] SVC_ON   = 2'b01;
  localparam logic [1:0] SVC_BUSY = 2'b10;

  localparam logic [1:0] COIN_50 = 2'd0;
  localparam logic [1:0] COIN_10 = 2'd1;
  localparam logic [1:0] COIN_5  = 2'd2;
  localparam logic [1:0] COIN_1  = 2'd3;

  localparam logic [1:0] ITEM_NONE = 2'b00;
  localparam logic [1:0] ITEM_A    = 2'b01;
  localparam logic [1:0] ITEM_B    = 2'b10;
  localparam logic [1:0] ITEM_C    = 2'b11;

  localparam logic [5:0] COIN50_VAL = 6'd50;
  localparam logic [5:0] COIN10_VAL = 6'd10;
  localparam logic [5:0] COIN5_VAL  = 6'd5;
  localparam logic [5:0] COIN1_VAL  = 6'd1;

  localparam logic [7:0] COST_A = 8'd8;
  localparam logic [7:0] COST_B = 8'd15;
  localparam logic [7:0] COST_C = 8'd22;

  function automatic logic [7:0] item_cost(input logic [1:0] item);
    case (item)
      ITEM_A:  return COST_A;
      ITEM_B:  return COST_B;
      ITEM_C:  return COST_C;
      default: return 8'd0;
    endcase
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_OFF = 2'd2,
    ST_REPORT   = 2'd3
  } state_e;

endpackage

// File: rtl/vending_coin_value.sv
// Weighted sum of four coin counts (50/10/5/1) into a 9-bit monetary value.
module vending_coin_value
  import vending_pkg::*;
(
  input  logic [2:0] c50_i,
  input  logic [2:0] c10_i,
  input  logic [2:0] c5_i,
  input  logic [2:0] c1_i,
  output logic [8:0] value_o
);

  assign value_o = 9'(c50_i) * 9'(COIN50_VAL)
                 + 9'(c10_i) * 9'(COIN10_VAL)
                 + 9'(c5_i)  * 9'(COIN5_VAL)
                 + 9'(c1_i)  * 9'(COIN1_VAL);

endmodule

// File: rtl/vending_customer.sv
// Purchase initiator: presents one request to the vending machine, waits for its
// delivery cycle, checks the returned change and reports one response upstream.
module vending_customer
  import vending_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_coin50,
  input  logic [1:0] req_coin10,
  input  logic [1:0] req_coin5,
  input  logic [1:0] req_coin1,
  input  logic [1:0] req_item,
  input  logic [1:0] vm_service,
  input  logic [1:0] vm_item,
  input  logic [2:0] vm_coin50,
  input  logic [2:0] vm_coin10,
  input  logic [2:0] vm_coin5,
  input  logic [2:0] vm_coin1,
  output logic [1:0] vm_coinIn50,
  output logic [1:0] vm_coinIn10,
  output logic [1:0] vm_coinIn5,
  output logic [1:0] vm_coinIn1,
  output logic [1:0] vm_itemIn,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_item,
  output logic [7:0] rsp_paid,
  output logic [8:0] rsp_change,
  output logic       rsp_err,
  output logic       rsp_timeout,
  output state_e     dbg_state_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);

  state_e           state_q, state_d;
  logic [1:0]       item_q, item_d;
  logic [7:0]       coins_q, coins_d;
  logic [8:0]       paid_q, paid_d;
  logic [1:0]       rsp_item_q, rsp_item_d;
  logic [8:0]       rsp_change_q, rsp_change_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_tmo_q, rsp_tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [8:0] paid_val;
  logic [8:0] change_val;
  logic [9:0] exp_change;
  logic       change_bad;
  logic       timed_out;
  logic       in_report;

  vending_coin_value u_paid (
    .c50_i   ({1'b0, req_coin50}),
    .c10_i   ({1'b0, req_coin10}),
    .c5_i    ({1'b0, req_coin5}),
    .c1_i    ({1'b0, req_coin1}),
    .value_o (paid_val)
  );

  vending_coin_value u_change (
    .c50_i   (vm_coin50),
    .c10_i   (vm_coin10),
    .c5_i    (vm_coin5),
    .c1_i    (vm_coin1),
    .value_o (change_val)
  );

  // 10-bit difference so an underpaid vend shows up as a mismatch instead of wrapping.
  assign exp_change = (vm_item != ITEM_NONE) ? 10'(paid_q) - 10'(item_cost(vm_item))
                                             : 10'(paid_q);
  assign change_bad = (exp_change != {1'b0, change_val}) ||
                      ((vm_item != ITEM_NONE) && (vm_item != item_q));
  assign timed_out  = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    item_d       = item_q;
    coins_d      = coins_q;
    paid_d       = paid_q;
    rsp_item_d   = rsp_item_q;
    rsp_change_d = rsp_change_q;
    rsp_err_d    = rsp_err_q;
    rsp_tmo_d    = rsp_tmo_q;
    cnt_d        = cnt_q;
    req_ready    = 1'b0;
    vm_itemIn    = 2'b00;
    vm_coinIn50  = 2'b00;
    vm_coinIn10  = 2'b00;
    vm_coinIn5   = 2'b00;
    vm_coinIn1   = 2'b00;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        cnt_d     = '0;
        if (req_valid) begin
          item_d  = req_item;
          coins_d = {req_coin50, req_coin10, req_coin5, req_coin1};
          paid_d  = paid_val;
          if (req_item == ITEM_NONE) begin
            state_d      = ST_REPORT;
            rsp_item_d   = ITEM_NONE;
            rsp_change_d = paid_val;
            rsp_err_d    = 1'b0;
            rsp_tmo_d    = 1'b0;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        vm_itemIn   = item_q;
        vm_coinIn50 = coins_q[7:6];
        vm_coinIn10 = coins_q[5:4];
        vm_coinIn5  = coins_q[3:2];
        vm_coinIn1  = coins_q[1:0];
        cnt_d       = cnt_q + CNT_W'(1);
        // An OFF here is the tail of an earlier delivery, so only ON makes progress.
        if (vm_service == SVC_ON) begin
          state_d = ST_WAIT_OFF;
        end else if (timed_out) begin
          state_d      = ST_REPORT;
          rsp_item_d   = ITEM_NONE;
          rsp_change_d = '0;
          rsp_err_d    = 1'b0;
          rsp_tmo_d    = 1'b1;
        end
      end
      ST_WAIT_OFF: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (vm_service == SVC_OFF) begin
          state_d      = ST_REPORT;
          rsp_item_d   = vm_item;
          rsp_change_d = change_val;
          rsp_err_d    = change_bad;
          rsp_tmo_d    = 1'b0;
        end else if (timed_out) begin
          state_d      = ST_REPORT;
          rsp_item_d   = ITEM_NONE;
          rsp_change_d = '0;
          rsp_err_d    = 1'b0;
          rsp_tmo_d    = 1'b1;
        end
      end
      ST_REPORT: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      item_q       <= '0;
      coins_q      <= '0;
      paid_q       <= '0;
      rsp_item_q   <= '0;
      rsp_change_q <= '0;
      rsp_err_q    <= 1'b0;
      rsp_tmo_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      item_q       <= item_d;
      coins_q      <= coins_d;
      paid_q       <= paid_d;
      rsp_item_q   <= rsp_item_d;
      rsp_change_q <= rsp_change_d;
      rsp_err_q    <= rsp_err_d;
      rsp_tmo_q    <= rsp_tmo_d;
      cnt_q        <= cnt_d;
    end
  end

  // Handshakes: a beat transfers on any edge where valid && ready; a raised valid and
  // its payload stay put until that edge. Response fields read zero outside REPORT.
  assign in_report   = (state_q == ST_REPORT);
  assign rsp_valid   = in_report;
  assign rsp_item    = in_report ? rsp_item_q   : '0;
  assign rsp_paid    = in_report ? paid_q[7:0]  : '0;
  assign rsp_change  = in_report ? rsp_change_q : '0;
  assign rsp_err     = in_report & rsp_err_q;
  assign rsp_timeout = in_report & rsp_tmo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vending_customer.sv
// Bench for vending_customer: mock vending machine, arithmetic response model,
// expected-response queue and randomized purchases.
module tb_vending_customer;
  import vending_pkg::*;

  localparam int MODE_NORMAL = 0;
  localparam int MODE_SHORT  = 1;
  localparam int MODE_WRONG  = 2;
  localparam int MODE_BUSY   = 3;
  localparam int MODE_SLOW   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_coin50 = '0, req_coin10 = '0, req_coin5 = '0, req_coin1 = '0;
  logic [1:0] req_item = '0;
  logic [1:0] vm_service = SVC_ON;
  logic [1:0] vm_item = '0;
  logic [2:0] vm_coin50 = '0, vm_coin10 = '0, vm_coin5 = '0, vm_coin1 = '0;
  logic [1:0] vm_coinIn50, vm_coinIn10, vm_coinIn5, vm_coinIn1, vm_itemIn;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [1:0] rsp_item;
  logic [7:0] rsp_paid;
  logic [8:0] rsp_change;
  logic       rsp_err, rsp_timeout;
  state_e     dbg_state;

  vending_customer #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_coin50(req_coin50), .req_coin10(req_coin10), .req_coin5(req_coin5), .req_coin1(req_coin1),
    .req_item(req_item),
    .vm_service(vm_service), .vm_item(vm_item),
    .vm_coin50(vm_coin50), .vm_coin10(vm_coin10), .vm_coin5(vm_coin5), .vm_coin1(vm_coin1),
    .vm_coinIn50(vm_coinIn50), .vm_coinIn10(vm_coinIn10), .vm_coinIn5(vm_coinIn5), .vm_coinIn1(vm_coinIn1),
    .vm_itemIn(vm_itemIn),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_item(rsp_item), .rsp_paid(rsp_paid), .rsp_change(rsp_change),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail = 0;
  logic [20:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // response model: {item[20:19], paid[18:11], change[10:2], err[1], timeout[0]}
  function automatic int coin_sum(input int c50, input int c10, input int c5, input int c1);
    return 50 * c50 + 10 * c10 + 5 * c5 + c1;
  endfunction

  function automatic int cost_of(input int item);
    case (item)
      1: return 8;
      2: return 15;
      3: return 22;
      default: return 0;
    endcase
  endfunction

  function automatic logic [20:0] model_rsp(input int item, input int paid, input int mode);
    int d_item, chg, err, tmo;
    d_item = 0; chg = paid; err = 0; tmo = 0;
    if (item != 0 && mode == MODE_BUSY) begin
      chg = 0; tmo = 1;
    end else if (item != 0) begin
      d_item = (paid >= cost_of(item)) ? item : 0;
      chg = (d_item != 0) ? paid - cost_of(item) : paid;
      if (mode == MODE_SHORT) begin
        chg = (chg == 0) ? 1 : chg - 1;
        err = 1;
      end
      if (mode == MODE_WRONG && d_item != 0) begin
        d_item = (d_item % 3) + 1;
        err = 1;
      end
    end
    return {2'(d_item), 8'(paid), 9'(chg), 1'(err), 1'(tmo)};
  endfunction

  // mock vending machine, reacting on the falling edge
  int cur_item = 0, cur_c50 = 0, cur_c10 = 0, cur_c5 = 0, cur_c1 = 0;
  int mock_mode = MODE_NORMAL;
  int m_phase = 0, m_wait = 0, m_v = 0;
  logic glitched = 1'b0;
  logic [20:0] m_ret = '0;

  always @(negedge clk) begin
    if (!reset) begin
      m_phase = 0; glitched = 1'b0;
      vm_service = SVC_ON; vm_item = '0;
      vm_coin50 = '0; vm_coin10 = '0; vm_coin5 = '0; vm_coin1 = '0;
    end else begin
      case (m_phase)
        0: begin
          vm_item = '0; vm_coin50 = '0; vm_coin10 = '0; vm_coin5 = '0; vm_coin1 = '0;
          if (mock_mode == MODE_BUSY) begin
            vm_service = SVC_BUSY;
          end else if (vm_itemIn != 2'b00 && !glitched && $urandom_range(0, 3) == 0) begin
            vm_service = SVC_OFF;
            vm_item = 2'($urandom);
            vm_coin1 = 3'($urandom);
            glitched = 1'b1;
          end else begin
            vm_service = SVC_ON;
            if (vm_itemIn != 2'b00) begin
              check_eq("issue_item", vm_itemIn, cur_item);
              check_eq("issue_c50", vm_coinIn50, cur_c50);
              check_eq("issue_c10", vm_coinIn10, cur_c10);
              check_eq("issue_c5", vm_coinIn5, cur_c5);
              check_eq("issue_c1", vm_coinIn1, cur_c1);
              m_ret = model_rsp(int'(vm_itemIn),
                                coin_sum(int'(vm_coinIn50), int'(vm_coinIn10),
                                         int'(vm_coinIn5), int'(vm_coinIn1)),
                                mock_mode);
              m_wait = (mock_mode == MODE_SLOW) ? 12 : $urandom_range(0, 3);
              m_phase = 1;
            end
          end
        end
        1: begin
          check_eq("issue_once", vm_itemIn, 0);
          vm_service = ($urandom_range(0, 1) == 1) ? SVC_BUSY : SVC_ON;
          if (m_wait == 0) begin
            vm_service = SVC_OFF;
            vm_item = m_ret[20:19];
            m_v = int'(m_ret[10:2]);
            vm_coin50 = 3'(m_v / 50); m_v = m_v % 50;
            vm_coin10 = 3'(m_v / 10); m_v = m_v % 10;
            vm_coin5  = 3'(m_v / 5);
            vm_coin1  = 3'(m_v % 5);
            m_phase = 2;
          end else begin
            m_wait--;
          end
        end
        default: begin
          check_eq("rsp_after_off", rsp_valid, 1);
          vm_service = SVC_ON; vm_item = '0;
          vm_coin50 = '0; vm_coin10 = '0; vm_coin5 = '0; vm_coin1 = '0;
          m_phase = 0; glitched = 1'b0;
        end
      endcase
    end
  end

  // driver tasks (entered and left on a falling edge)
  task automatic drive_req(input int item, input int c50, input int c10, input int c5,
                           input int c1, input int mode);
    cur_item = item; cur_c50 = c50; cur_c10 = c10; cur_c5 = c5; cur_c1 = c1;
    mock_mode = mode;
    req_valid = 1'b1; req_item = 2'(item);
    req_coin50 = 2'(c50); req_coin10 = 2'(c10); req_coin5 = 2'(c5); req_coin1 = 2'(c1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_item = '0;
    req_coin50 = '0; req_coin10 = '0; req_coin5 = '0; req_coin1 = '0;
  endtask

  task automatic run_txn(input int item, input int c50, input int c10, input int c5,
                         input int c1, input int mode, input int hold);
    int edges;
    logic [20:0] e;
    edges = 0;
    while (!req_ready && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    check_eq("req_ready_before", req_ready, 1);
    exp_q.push_back(model_rsp(item, coin_sum(c50, c10, c5, c1), mode));
    drive_req(item, c50, c10, c5, c1, mode);
    edges = 0;
    while (!rsp_valid && edges < 300) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check_eq("rsp_valid_seen", rsp_valid, 1);
    if (mode == MODE_BUSY && item != 0) check_eq("timeout_latency", edges, 64);
    for (int i = 0; i < hold; i++) begin
      check_eq("hold_fields", {rsp_item, rsp_paid, rsp_change, rsp_err, rsp_timeout}, exp_q[0]);
      check_eq("hold_req_ready", req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    e = exp_q.pop_front();
    check_eq("rsp_item", rsp_item, e[20:19]);
    check_eq("rsp_paid", rsp_paid, e[18:11]);
    check_eq("rsp_change", rsp_change, e[10:2]);
    check_eq("rsp_err", rsp_err, e[1]);
    check_eq("rsp_timeout", rsp_timeout, e[0]);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("req_ready_after", req_ready, 1);
    check_eq("rsp_valid_after", rsp_valid, 0);
  endtask

  int edges_r;
  int r_mode, r_sel;

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_fields", {rsp_item, rsp_paid, rsp_change, rsp_err, rsp_timeout}, 0);
    check_eq("rst_vm_out", {vm_itemIn, vm_coinIn50, vm_coinIn10, vm_coinIn5, vm_coinIn1}, 0);
    check_eq("rst_state", dbg_state, ST_IDLE);

    run_txn(1, 0, 1, 0, 0, MODE_NORMAL, 0);  // A for 10 -> change 2
    run_txn(3, 0, 0, 1, 0, MODE_NORMAL, 1);  // C underpaid -> refund 5
    run_txn(1, 0, 1, 0, 0, MODE_SHORT, 0);   // change 1 -> err
    run_txn(2, 0, 2, 0, 0, MODE_BUSY, 0);    // timeout
    run_txn(2, 1, 0, 0, 0, MODE_NORMAL, 5);  // response back-pressure
    run_txn(0, 1, 1, 1, 1, MODE_NORMAL, 2);  // no item -> refund 66
    run_txn(3, 3, 3, 3, 3, MODE_WRONG, 0);   // paid 198, wrong item

    // reset while waiting for delivery
    exp_q.delete();
    drive_req(1, 0, 1, 0, 0, MODE_SLOW);
    edges_r = 0;
    while (m_phase != 1 && edges_r < 50) begin
      @(negedge clk);
      edges_r++;
    end
    @(negedge clk);
    check_eq("pre_reset_state", dbg_state, ST_WAIT_OFF);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_rsp_valid", rsp_valid, 0);
    check_eq("midrst_vm_itemIn", vm_itemIn, 0);
    check_eq("midrst_req_ready", req_ready, 1);
    check_eq("midrst_rsp_fields", {rsp_item, rsp_paid, rsp_change, rsp_err, rsp_timeout}, 0);
    @(negedge clk);
    reset = 1'b1;
    run_txn(2, 0, 2, 0, 0, MODE_NORMAL, 0);

    for (int n = 0; n < 40; n++) begin
      r_sel = $urandom_range(0, 19);
      r_mode = (r_sel == 0) ? MODE_BUSY : (r_sel <= 2) ? MODE_SHORT :
               (r_sel <= 4) ? MODE_WRONG : MODE_NORMAL;
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), r_mode, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
